// File: rtl/adder_pkg.sv
// Shared types and reference helpers for the bit-serial approximate adder.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned MaxWidth = 64;

  // Golden LOA result {cout, sum}: OR on the low k bits, exact above them.
  // The carry into bit k is a[k-1]&b[k-1].
  function automatic logic [MaxWidth:0] loa_ref(input logic [MaxWidth-1:0] a,
                                                input logic [MaxWidth-1:0] b,
                                                input logic                cin,
                                                input int                  k,
                                                input int                  width);
    logic [MaxWidth:0] res;
    logic              c;
    int                kk;
    res = '0;
    kk  = (k > width) ? width : k;
    c   = cin;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < width) begin
        if (i < kk) begin
          res[i] = a[i] | b[i];
          c      = (i == kk - 1) ? (a[i] & b[i]) : 1'b0;
        end else begin
          res[i] = a[i] ^ b[i] ^ c;
          c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
      end
    end
    res[width] = c;
    return res;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KW    = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [KW-1:0]    approx_k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, approx_k, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, approx_k, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/Full_Adder.sv
// One-bit full-adder cell shared across all bit positions of the serial adder.
module Full_Adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles,
// with a lower-part OR approximation over the first approx_k bits.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KW    = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d, idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;

  logic fa_sum, fa_cout;
  logic approx, bit_res, carry_res;

  Full_Adder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // Per-bit datapath: OR below k, exact cell at and above k.
  always_comb begin
    approx  = (idx_q < k_q);
    bit_res = approx ? (a_q[0] | b_q[0]) : fa_sum;
    if (approx) begin
      carry_res = (idx_q == k_q - KW'(1)) ? (a_q[0] & b_q[0]) : 1'b0;
    end else begin
      carry_res = fa_cout;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          k_d     = (bus.approx_k > KW'(WIDTH)) ? KW'(WIDTH) : bus.approx_k;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_res, sum_q[WIDTH-1:1]};
        carry_d = carry_res;
        idx_d   = idx_q + KW'(1);
        if (idx_q == KW'(WIDTH - 1)) begin
          cout_d  = carry_res;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic LOA model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: low kk bits are a|b, the upper part is an ordinary addition of
  // the shifted operands plus a carry of a[kk-1]&b[kk-1] (or cin when kk=0).
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input int k);
    int unsigned kk, mask, low, c, hi, full;
    logic [31:0] fv;
    kk   = (k > W) ? W : k;
    mask = (32'd1 << kk) - 1;
    low  = (a | b) & mask;
    if (kk == 0) c = cin;
    else c = ((a >> (kk - 1)) & (b >> (kk - 1))) & 1;
    hi   = (a >> kk) + (b >> kk) + c;
    full = (hi << kk) | low;
    fv   = full;
    return fv[8:0];
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [3:0] k, input int hold,
                        output logic [7:0] s, output logic co, output int lat,
                        output logic rdy_low);
    int guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = a; bus.b = b; bus.cin = cin; bus.approx_k = k; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
    lat = 0; rdy_low = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    s = bus.sum; co = bus.cout;
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.approx_k = '0;
    #12;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 8'h00 ||
        bus.cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] av[7] = '{8'h5A, 8'hFF, 8'hFF, 8'h0F, 8'h18, 8'h81, 8'h10};
    logic [7:0] bv[7] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h08, 8'h82, 8'h20};
    logic       cv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] kv[7] = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd15, 4'd0};
    logic [8:0] ev[7] = '{9'h096, 9'h100, 9'h100, 9'h00F, 9'h028, 9'h183, 9'h030};
    logic [7:0] s; logic co; int lat; logic rl;
    for (int i = 0; i < 7; i++) begin
      run_op(av[i], bv[i], cv[i], kv[i], 0, s, co, lat, rl);
      n_cmp++;
      if ({co, s} !== ev[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                 i, co, s, ev[i][8], ev[i][7:0]);
      end
      n_cmp++;
      if (lat !== W || rl !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_lat_%0d: got lat=%0d rdy_low=%b, want %0d 1", i, lat, rl, W);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_r;
    int lat;
    exp_r = model(8'hC3, 8'h5E, 1'b1, 2);
    bus.a = 8'hC3; bus.b = 8'h5E; bus.cin = 1'b1; bus.approx_k = 4'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== W) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d, want %0d", lat, W);
    end
    bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.approx_k = 4'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.cout, bus.sum} !== exp_r) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 %b %h", i,
                 bus.out_valid, bus.in_ready, bus.cout, bus.sum, exp_r[8], exp_r[7:0]);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.cout, bus.sum} !== exp_r) begin
      n_bad++;
      $display("FAIL bp_release: got rdy=%b vld=%b cout=%b sum=%h, want 1 0 %b %h",
               bus.in_ready, bus.out_valid, bus.cout, bus.sum, exp_r[8], exp_r[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, s; logic c, co, rl; logic [3:0] k; int lat;
    logic [8:0] e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom); k = 4'($urandom_range(0, 9));
      e = model(a, b, c, int'(k));
      run_op(a, b, c, k, 0, s, co, lat, rl);
      n_cmp++;
      if ({co, s} !== e || lat !== W) begin
        n_bad++;
        $display("FAIL b2b_%0d: a=%h b=%h cin=%b k=%0d got %b/%h lat=%0d, want %b/%h lat=%0d",
                 i, a, b, c, k, co, s, lat, e[8], e[7:0], W);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic co, rl; int lat;
    bus.a = 8'hA7; bus.b = 8'h6B; bus.cin = 1'b1; bus.approx_k = 4'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 8'h00 ||
        bus.cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8'h20, 1'b0, 4'd0, 0, s, co, lat, rl);
    n_cmp++;
    if ({co, s} !== 9'h030 || lat !== W) begin
      n_bad++;
      $display("FAIL post_reset_op: got %b/%h lat=%0d, want 0/30 lat=%0d", co, s, lat, W);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic c, co, rl; logic [3:0] k; int lat;
    logic [8:0] e;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom); k = 4'($urandom);
      e = model(a, b, c, int'(k));
      run_op(a, b, c, k, $urandom_range(0, 3), s, co, lat, rl);
      n_cmp++;
      if ({co, s} !== e || lat !== W || rl !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_%0d: a=%h b=%h cin=%b k=%0d got %b/%h lat=%0d rdy_low=%b, want %b/%h lat=%0d",
                 i, a, b, c, k, co, s, lat, rl, e[8], e[7:0], W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
